// File: rtl/sprite_rom_arbiter_if.sv
// Bus bundle between the sprite drawers, the arbiter and the shared ROM.
// Drawer/ROM side uses master; the arbiter uses slave.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 24
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic                      rsp_valid;
  logic [IDW-1:0]            rsp_id;
  logic [DATA_W-1:0]         rsp_data;

`ifdef ARB_BURST_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;

  modport master (
    output req, req_addr, req_lock, rom_data,
    input  gnt, rom_addr,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, req_addr, req_lock, rom_data,
    output gnt, rom_addr,
    output rsp_valid, rsp_id, rsp_data
  );
`else
  modport master (
    output req, req_addr, rom_data,
    input  gnt, rom_addr,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, req_addr, rom_data,
    output gnt, rom_addr,
    output rsp_valid, rsp_id, rsp_data
  );
`endif

endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output sprite ROM port.
// Ports: Clk, Reset_n (async, active-low), bus (slave):
//   req/req_addr in, gnt out (one-hot, comb), rom_addr out (reg),
//   rom_data in, rsp_valid/rsp_id/rsp_data out (tagged response).
// Optional ARB_BURST_LOCK_EN adds req_lock and burst locking.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 24,
  parameter int ROM_LAT   = 1,
  parameter int BURST_MAX = 64
) (
  input logic Clk,
  input logic Reset_n,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int DEPTH = 1 + ROM_LAT;

  logic [IDW-1:0]              ptr_q, ptr_d;
  logic [ADDR_W-1:0]           rom_addr_q;
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][IDW-1:0]   id_q;

  logic [NUM_REQ-1:0]          rr_gnt;
  logic [IDW-1:0]              rr_id;
  logic                        rr_hit;

  logic [NUM_REQ-1:0]          gnt_c;
  logic [IDW-1:0]              win_id;
  logic                        hit;
  logic                        lock_hit;
  logic                        xfer;
  logic [ADDR_W-1:0]           sel_addr;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    int j;
    rr_gnt = '0;
    rr_id  = '0;
    rr_hit = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!rr_hit && bus.req[j]) begin
        rr_hit    = 1'b1;
        rr_id     = IDW'(j);
        rr_gnt[j] = 1'b1;
      end
    end
  end

`ifdef ARB_BURST_LOCK_EN
  logic [IDW-1:0] last_q;
  logic           last_vld_q;
  logic [7:0]     burst_q;

  // burst_q counts grants in the current run, first one included,
  // so the holder keeps at most BURST_MAX grants in a row.
  assign lock_hit = last_vld_q
                  & bus.req[last_q]
                  & bus.req_lock[last_q]
                  & (burst_q < 8'(BURST_MAX));

  always_comb begin
    gnt_c  = rr_gnt;
    win_id = rr_id;
    hit    = rr_hit;
    if (lock_hit) begin
      gnt_c  = '0;
      gnt_c[last_q] = 1'b1;
      win_id = last_q;
      hit    = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      burst_q    <= '0;
    end else if (xfer) begin
      last_q     <= win_id;
      last_vld_q <= 1'b1;
      burst_q    <= lock_hit ? burst_q + 8'd1 : 8'd1;
    end else begin
      burst_q    <= '0;
    end
  end
`else
  assign lock_hit = 1'b0;

  always_comb begin
    gnt_c  = rr_gnt;
    win_id = rr_id;
    hit    = rr_hit;
  end
`endif

  assign xfer     = Reset_n & hit;
  assign bus.gnt  = Reset_n ? gnt_c : '0;
  assign sel_addr = bus.req_addr[win_id*ADDR_W +: ADDR_W];

  // Locked re-grants leave the pointer where it is.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && !lock_hit) begin
      if (win_id == IDW'(NUM_REQ-1)) ptr_d = '0;
      else ptr_d = win_id + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      vld_q      <= '0;
      id_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) rom_addr_q <= sel_addr;
      vld_q[0] <= xfer;
      id_q[0]  <= win_id;
      for (int s = 1; s < DEPTH; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = vld_q[DEPTH-1];
  assign bus.rsp_id    = id_q[DEPTH-1];
  assign bus.rsp_data  = bus.rom_data;

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one registered-output sprite/frame ROM read port (19-bit address, 24-bit palette-resolved RGB out, 1-cycle read latency) between NUM_REQ sprite drawers, e.g. player sprites, win-screen overlays and background fetch.
- Round-robin grant per cycle; each accepted read is tagged with the requester ID.
- The tag is returned with the ROM data after a fixed pipeline delay.
- Sits between the per-sprite draw logic and a single frameRAM-style ROM instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 19, ROM read address width
DATA_W, 24, ROM output width (RGB)
ROM_LAT, 1, ROM read latency in clocks (address in to data out)
BURST_MAX, 64, max consecutive locked grants (used only with the optional feature)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester read request, held until granted
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
gnt  out  NUM_REQ  one-hot grant (combinational), all-zero when idle
rom_addr  out  ADDR_W  registered address to ROM read_address
rom_data  in  DATA_W  ROM data_Out
rsp_valid  out  1  response valid
rsp_id  out  $clog2(NUM_REQ)  requester index of the response
rsp_data  out  DATA_W  response pixel data

Behaviour:
- One clock (Clk); reset is asynchronous and active-low (Reset_n); all flops clear immediately when Reset_n is low.
- Reset values:
  - rom_addr = 0, rsp_valid = 0, rsp_id = 0.
  - Round-robin pointer = 0; valid/ID pipeline all 0.
  - gnt forced to 0 while Reset_n is low.
- Handshake: a transfer occurs in cycle T when req[i] and gnt[i] are both 1.
  - A requester must hold req and req_addr stable until granted; dropping req before grant is legal and cancels the request.
- Arbitration: combinational round-robin.
  - Search starts at the pointer, wrapping from NUM_REQ-1 to 0.
  - At most one gnt bit high per cycle; gnt is 0 when req is 0.
  - On a transfer to i, pointer <= (i+1) mod NUM_REQ. With no transfer, the pointer holds.
- Fairness: a continuously asserted req is granted within NUM_REQ cycles.
- Pipeline, for a transfer in cycle T:
  - rom_addr <= req_addr[i] at the end of T, so rom_addr is valid in T+1.
  - The ROM registers its data on the T+ROM_LAT edge.
  - rsp_valid = 1, rsp_id = i and rsp_data = rom_data in cycle T+1+ROM_LAT; with defaults that is T+2.
- Valid/ID travel through a (1+ROM_LAT)-deep shift register. Back-to-back transfers give back-to-back responses in grant order, with no bubbles and no stalls. There is no backpressure on the response side.
- rsp_data is rom_data passed through combinationally; it is meaningful only when rsp_valid = 1.
- Idle cycles: rom_addr holds its last value; a 0 enters the valid pipe.
- Reset mid-operation: all in-flight responses are discarded, with rsp_valid low immediately. After release, the first grant searches from index 0.
- Simultaneous req rise on several lines: the lowest index at or after the pointer wins.

Optional Feature:
Macro ARB_BURST_LOCK_EN.
- Defined:
  - Adds input req_lock [NUM_REQ].
  - If the last granted requester i still has req[i] and req_lock[i] high, it is re-granted and the pointer is not advanced.
  - A burst counter (8 bits, reset 0) counts consecutive locked grants. At BURST_MAX the lock is ignored for one arbitration, the pointer advances normally and the counter clears.
  - The counter also clears whenever the grant goes to a different requester or there is no transfer.
- Undefined: the port is absent and there is pure round-robin every cycle.

Test Plan:
1. Reset: drive Reset_n = 0 mid-traffic with rsp_valid = 1 -> rsp_valid, gnt and rom_addr are 0 in the same cycle. After release with req = 4'b1001 -> gnt = 4'b0001.
2. Single read: req[2] = 1, addr 19'h00123 in cycle T -> gnt = 4'b0100 in T; rom_addr = 19'h00123 in T+1; rsp_valid = 1, rsp_id = 2 in T+2, with rsp_data equal to the ROM model word at 0x123.
3. Saturation: all req held high, distinct addresses, 12 cycles -> grants 0,1,2,3 repeating. Responses arrive back-to-back in the same ID order, 2 cycles later, with 12 consecutive valid cycles.
4. Pointer: grant to 1, then req = 4'b1001 -> grant 3 first, then 0.
5. Cancel/idle: req[0] pulsed for 1 cycle while 1 holds the grant -> no transfer for 0. rsp_valid count equals the transfer count.
6. With ARB_BURST_LOCK_EN: req[1] = req_lock[1] = 1 for 80 cycles, req[2] = 1 -> exactly 64 consecutive grants to 1, then 1 grant to 2, then locking to 1 resumes.
